// File: rtl/mult_div_pkg.sv
// Shared types for the multiply/divide unit and the control unit that drives it.
// State and operation encodings plus the default operand width.
package mult_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } op_t;

endpackage

// File: rtl/mult_div_abs.sv
// Conditional two's-complement negate: res = neg ? -val : val.
// With neg tied to the sign bit it yields the magnitude.
module mult_div_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Signed radix-2 multiply / restoring divide producing HI/LO; MULTDIV_DIVZERO_EXC_EN enables the zero-divisor exception.
// Latency: start edge N, results and done at edge N+WIDTH+1 (zero-divisor exception: done/divZero at edge N).
// No backpressure: requests seen while busy are dropped, done is a single-cycle pulse.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multOP,
  input  logic             divOP,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  op_t              op;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             sgn_q;
  logic             sgn_r;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic               geq;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mult_div_abs #(.W(WIDTH)) u_abs_a (.val(a), .neg(a[WIDTH-1]), .res(a_mag));
  mult_div_abs #(.W(WIDTH)) u_abs_b (.val(b), .neg(b[WIDTH-1]), .res(b_mag));

  // Multiply step: acc_lo holds the unconsumed multiplier bits below the growing product.
  assign addend  = acc_lo[0] ? opnd : {WIDTH{1'b0}};
  assign add_sum = {1'b0, acc_hi} + {1'b0, addend};

  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign shl  = {acc_hi, acc_lo[WIDTH-1]};
  assign geq  = shl >= {1'b0, opnd};
  assign diff = shl[WIDTH-1:0] - opnd;

  mult_div_abs #(.W(2*WIDTH)) u_fix_p (.val({acc_hi, acc_lo}), .neg(sgn_q), .res(prod_fix));
  mult_div_abs #(.W(WIDTH))   u_fix_q (.val(acc_lo), .neg(sgn_q), .res(quo_fix));
  mult_div_abs #(.W(WIDTH))   u_fix_r (.val(acc_hi), .neg(sgn_r), .res(rem_fix));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op      <= MUL;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      sgn_q   <= 1'b0;
      sgn_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      case (state)
        IDLE: begin
          if (multOP) begin
            op     <= MUL;
            acc_hi <= '0;
            acc_lo <= b_mag;
            opnd   <= a_mag;
            sgn_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            sgn_r  <= a[WIDTH-1];
            cnt    <= '0;
            state  <= RUN;
          end else if (divOP) begin
`ifdef MULTDIV_DIVZERO_EXC_EN
            if (b == '0) begin
              done    <= 1'b1;
              divZero <= 1'b1;
            end else begin
`else
            begin
`endif
              op     <= DIV;
              acc_hi <= '0;
              acc_lo <= a_mag;
              opnd   <= b_mag;
              sgn_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              sgn_r  <= a[WIDTH-1];
              cnt    <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (op == MUL) begin
            acc_hi <= add_sum[WIDTH:1];
            acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
          end else if (geq) begin
            acc_hi <= diff;
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= shl[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op == MUL) begin
            {hi, lo} <= prod_fix;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
